// File: rtl/vga_pkg.sv
// Shared VGA constants and the bounce-direction type used by the sprite overlay.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam logic [9:0] COORD_INVALID = 10'h3FF;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing sprite: position plus direction, stepped once per frame tick.
// The direction flag is the state of a two-state FSM, visible as the signal "dir".
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 600,
  parameter int STEP  = 2
) (
  input  logic       iPixclk,
  input  logic       iRst,
  input  logic       tick,
  output logic [9:0] pos
);

  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  dir_t        dir;
  dir_t        dir_next;
  logic [9:0]  pos_next;
  logic [10:0] pos_w;
  logic [10:0] sum_w;
  logic [10:0] diff_w;

  always_ff @(posedge iPixclk or negedge iRst) begin
    if (!iRst) begin
      pos <= 10'd0;
      dir <= DIR_POS;
    end else begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

  // 11-bit arithmetic keeps the limit compare free of wrap-around.
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    pos_w    = {1'b0, pos};
    sum_w    = pos_w + STEP_W;
    diff_w   = pos_w - STEP_W;
    if (tick) begin
      if (dir == DIR_POS) begin
        if (sum_w >= LIMIT_W) begin
          pos_next = LIMIT_W[9:0];
          dir_next = DIR_NEG;
        end else begin
          pos_next = sum_w[9:0];
        end
      end else begin
        if (pos_w <= STEP_W) begin
          pos_next = 10'd0;
          dir_next = DIR_POS;
        end else begin
          pos_next = diff_w[9:0];
        end
      end
    end
  end

endmodule

// File: rtl/vga_sprite_overlay.sv
// Bouncing square sprite composited over the background pixel stream.
// Optional white 2-pixel sprite outline when VGA_SPRITE_BORDER_EN is defined.
module vga_sprite_overlay
  import vga_pkg::*;
#(
  parameter int          SPRITE_SIZE = 40,
  parameter int          STEP        = 2,
  parameter logic [23:0] SPRITE_RGB  = 24'h00FF00
) (
  input  logic        iPixclk,
  input  logic        iRst,
  input  logic        iVs,
  input  logic [9:0]  iCoord_X,
  input  logic [9:0]  iCoord_Y,
  input  logic [23:0] iRGB,
  output logic [23:0] oRGB,
  output logic [9:0]  oPos_X,
  output logic [9:0]  oPos_Y,
  output logic [7:0]  oFrameCnt
);

  localparam logic [10:0] SIZE_W = 11'(SPRITE_SIZE);

  logic vs_q;
  logic frame_tick;
  logic hit;
  logic hit_q;
  logic coord_valid;
  logic in_x;
  logic in_y;
  logic [10:0] cx;
  logic [10:0] cy;
  logic [10:0] px;
  logic [10:0] py;

  // Falling edge of the active-low vsync marks the start of each new frame.
  assign frame_tick = vs_q & ~iVs;

  vga_bounce_axis #(.LIMIT(H_ACTIVE - SPRITE_SIZE), .STEP(STEP)) u_axis_x (
    .iPixclk (iPixclk),
    .iRst    (iRst),
    .tick    (frame_tick),
    .pos     (oPos_X)
  );

  vga_bounce_axis #(.LIMIT(V_ACTIVE - SPRITE_SIZE), .STEP(STEP)) u_axis_y (
    .iPixclk (iPixclk),
    .iRst    (iRst),
    .tick    (frame_tick),
    .pos     (oPos_Y)
  );

  always_comb begin
    cx          = {1'b0, iCoord_X};
    cy          = {1'b0, iCoord_Y};
    px          = {1'b0, oPos_X};
    py          = {1'b0, oPos_Y};
    coord_valid = (iCoord_X != COORD_INVALID) && (iCoord_Y != COORD_INVALID);
    in_x        = (cx >= px) && (cx < px + SIZE_W);
    in_y        = (cy >= py) && (cy < py + SIZE_W);
    hit         = coord_valid && in_x && in_y;
  end

  always_ff @(posedge iPixclk or negedge iRst) begin
    if (!iRst) begin
      vs_q      <= 1'b1;
      hit_q     <= 1'b0;
      oFrameCnt <= 8'd0;
    end else begin
      vs_q  <= iVs;
      hit_q <= hit;
      if (frame_tick) oFrameCnt <= oFrameCnt + 8'd1;
    end
  end

`ifdef VGA_SPRITE_BORDER_EN
  logic [10:0] rel_x;
  logic [10:0] rel_y;
  logic        border;
  logic        border_q;

  // Relative offsets are only meaningful when hit is set; border_q is gated by hit_q.
  always_comb begin
    rel_x  = cx - px;
    rel_y  = cy - py;
    border = (rel_x < 11'd2) || (rel_x >= SIZE_W - 11'd2) ||
             (rel_y < 11'd2) || (rel_y >= SIZE_W - 11'd2);
  end

  always_ff @(posedge iPixclk or negedge iRst) begin
    if (!iRst) begin
      border_q <= 1'b0;
      oRGB     <= 24'd0;
    end else begin
      border_q <= border;
      if (hit_q) oRGB <= border_q ? 24'hFFFFFF : SPRITE_RGB;
      else       oRGB <= iRGB;
    end
  end
`else
  always_ff @(posedge iPixclk or negedge iRst) begin
    if (!iRst) oRGB <= 24'd0;
    else       oRGB <= hit_q ? SPRITE_RGB : iRGB;
  end
`endif

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed bench for vga_sprite_overlay: reset, bounce motion, compositing table and latency.
module tb_vga_sprite_overlay;

`ifdef VGA_SPRITE_BORDER_EN
  localparam logic [23:0] BRD = 24'hFFFFFF;
`else
  localparam logic [23:0] BRD = 24'h00FF00;
`endif
  localparam logic [23:0] SPR = 24'h00FF00;

  logic        iPixclk;
  logic        iRst;
  logic        iVs;
  logic [9:0]  iCoord_X;
  logic [9:0]  iCoord_Y;
  logic [23:0] iRGB;
  logic [23:0] oRGB;
  logic [9:0]  oPos_X;
  logic [9:0]  oPos_Y;
  logic [7:0]  oFrameCnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[10];

  vga_sprite_overlay dut (
    .iPixclk   (iPixclk),
    .iRst      (iRst),
    .iVs       (iVs),
    .iCoord_X  (iCoord_X),
    .iCoord_Y  (iCoord_Y),
    .iRGB      (iRGB),
    .oRGB      (oRGB),
    .oPos_X    (oPos_X),
    .oPos_Y    (oPos_Y),
    .oFrameCnt (oFrameCnt)
  );

  // Clock and reset
  initial iPixclk = 1'b0;
  always #5 iPixclk = ~iPixclk;

  // Scoreboard helper
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Driver: one full vsync pulse, tick fires on the first posedge after iVs falls
  task automatic frame();
    iVs = 1'b0;
    repeat (2) @(negedge iPixclk);
    iVs = 1'b1;
    repeat (2) @(negedge iPixclk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
    iCoord_X = x;
    iCoord_Y = y;
    iRGB     = rgb;
  endtask

  initial begin
    vecs[0] = '{10'd39,  10'd39,  24'hFFFFFF, BRD};
    vecs[1] = '{10'd40,  10'd0,   24'hFFFFFF, 24'hFFFFFF};
    vecs[2] = '{10'h3FF, 10'd10,  24'hFF0000, 24'hFF0000};
    vecs[3] = '{10'd10,  10'h3FF, 24'hFF0000, 24'hFF0000};
    vecs[4] = '{10'd20,  10'd20,  24'h000000, SPR};
    vecs[5] = '{10'd1,   10'd20,  24'h000000, BRD};
    vecs[6] = '{10'd2,   10'd20,  24'h000000, SPR};
    vecs[7] = '{10'd20,  10'd40,  24'h0000FF, 24'h0000FF};
    vecs[8] = '{10'd639, 10'd479, 24'hABCDEF, 24'hABCDEF};
    vecs[9] = '{10'd0,   10'd39,  24'h111111, BRD};

    iRst = 1'b0;
    iVs  = 1'b1;
    drive_pix(10'h3FF, 10'h3FF, 24'h123456);
    #1;
    check("reset_rgb",   oRGB, 24'd0);
    check("reset_pos_x", {14'd0, oPos_X}, 24'd0);
    check("reset_pos_y", {14'd0, oPos_Y}, 24'd0);
    check("reset_cnt",   {16'd0, oFrameCnt}, 24'd0);

    repeat (3) @(negedge iPixclk);
    iRst = 1'b1;
    repeat (4) @(negedge iPixclk);
    check("release_pos_x", {14'd0, oPos_X}, 24'd0);
    check("release_cnt",   {16'd0, oFrameCnt}, 24'd0);

    // Compositing table at sprite position (0,0)
    for (int i = 0; i < 10; i++) begin
      drive_pix(vecs[i].x, vecs[i].y, vecs[i].rgb);
      repeat (3) @(negedge iPixclk);
      check($sformatf("vec%0d", i), oRGB, vecs[i].exp);
    end

    // Latency: two cycles from coords, one cycle from iRGB
    drive_pix(10'd40, 10'd0, 24'hFF0000);
    repeat (3) @(negedge iPixclk);
    drive_pix(10'd20, 10'd20, 24'hFF0000);
    @(negedge iPixclk);
    check("lat_enter_c1", oRGB, 24'hFF0000);
    @(negedge iPixclk);
    check("lat_enter_c2", oRGB, SPR);
    drive_pix(10'd40, 10'd0, 24'hFF0000);
    @(negedge iPixclk);
    check("lat_leave_c1", oRGB, SPR);
    @(negedge iPixclk);
    check("lat_leave_c2", oRGB, 24'hFF0000);

    // iVs held low must not produce repeated ticks
    drive_pix(10'h3FF, 10'h3FF, 24'h000000);
    iVs = 1'b0;
    repeat (6) @(negedge iPixclk);
    iVs = 1'b1;
    repeat (2) @(negedge iPixclk);
    check("tick1_pos_x", {14'd0, oPos_X}, 24'd2);
    check("tick1_pos_y", {14'd0, oPos_Y}, 24'd2);
    check("tick1_cnt",   {16'd0, oFrameCnt}, 24'd1);

    frames(219);
    check("t220_pos_y", {14'd0, oPos_Y}, 24'd440);
    check("t220_pos_x", {14'd0, oPos_X}, 24'd440);
    frame();
    check("t221_pos_y", {14'd0, oPos_Y}, 24'd438);
    frames(79);
    check("t300_pos_x", {14'd0, oPos_X}, 24'd600);
    check("t300_dir_x", {23'd0, dut.u_axis_x.dir}, 24'd1);
    check("t300_pos_y", {14'd0, oPos_Y}, 24'd280);
    check("t300_cnt",   {16'd0, oFrameCnt}, 24'd44);
    frame();
    check("t301_pos_x", {14'd0, oPos_X}, 24'd598);
    check("t301_pos_y", {14'd0, oPos_Y}, 24'd278);
    check("t301_cnt",   {16'd0, oFrameCnt}, 24'd45);

    // Compositing at the moved position (598,278)
    drive_pix(10'd637, 10'd317, 24'h222222);
    repeat (3) @(negedge iPixclk);
    check("moved_corner", oRGB, BRD);
    drive_pix(10'd600, 10'd300, 24'h222222);
    repeat (3) @(negedge iPixclk);
    check("moved_inner", oRGB, SPR);
    drive_pix(10'd638, 10'd300, 24'h222222);
    repeat (3) @(negedge iPixclk);
    check("moved_right_out", oRGB, 24'h222222);
    drive_pix(10'd597, 10'd300, 24'h333333);
    repeat (3) @(negedge iPixclk);
    check("moved_left_out", oRGB, 24'h333333);

    // Asynchronous reset mid-run, then restart from the next real vsync edge
    #2;
    iRst = 1'b0;
    #1;
    check("areset_rgb",   oRGB, 24'd0);
    check("areset_pos_x", {14'd0, oPos_X}, 24'd0);
    check("areset_cnt",   {16'd0, oFrameCnt}, 24'd0);
    @(negedge iPixclk);
    iRst = 1'b1;
    repeat (3) @(negedge iPixclk);
    check("rerelease_pos_y", {14'd0, oPos_Y}, 24'd0);
    frame();
    check("retick_pos_x", {14'd0, oPos_X}, 24'd2);
    check("retick_pos_y", {14'd0, oPos_Y}, 24'd2);
    check("retick_cnt",   {16'd0, oFrameCnt}, 24'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vga_sprite_overlay.md
VGA_SPRITE_OVERLAY -- requirements
Module: vga_sprite_overlay

Interface
REQ-001 SHALL have parameter SPRITE_SIZE, default 40, meaning the sprite edge length in pixels.
REQ-002 SHALL have parameter STEP, default 2, meaning the pixels moved per axis per frame.
REQ-003 SHALL have parameter SPRITE_RGB, default 24'h00FF00, meaning the sprite fill colour.
REQ-004 SHALL have port iPixclk, input, 1 bit: pixel clock.
REQ-005 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port iVs, input, 1 bit: vertical sync, active-low, from the timing generator.
REQ-007 SHALL have port iCoord_X, input, 10 bits: active X in 0..639; 10'h3FF means invalid.
REQ-008 SHALL have port iCoord_Y, input, 10 bits: active Y in 0..479; 10'h3FF means invalid.
REQ-009 SHALL have port iRGB, input, 24 bits: background pixel lagging iCoord_* by 1 cycle (chessboard output).
REQ-010 SHALL have port oRGB, output, 24 bits: composited pixel to the DAC interface.
REQ-011 SHALL have port oPos_X, output, 10 bits: current sprite left edge.
REQ-012 SHALL have port oPos_Y, output, 10 bits: current sprite top edge.
REQ-013 SHALL have port oFrameCnt, output, 8 bits: frame-tick counter.

Function
REQ-014 SHALL register iVs once (vs_q); frame_tick = vs_q & ~iVs, i.e. a 1-cycle pulse on the iVs falling edge.
REQ-015 SHALL update oPos_X/oPos_Y, the direction flags and oFrameCnt only on cycles where frame_tick is 1.
REQ-016 SHALL, when moving +X on a tick: if oPos_X + STEP >= 640 - SPRITE_SIZE, load 640 - SPRITE_SIZE and set the direction to -X; else add STEP.
REQ-017 SHALL, when moving -X on a tick: if oPos_X <= STEP, load 0 and set the direction to +X; else subtract STEP.
REQ-018 SHALL update Y identically to REQ-016/017, with limit 480 - SPRITE_SIZE; the X and Y axes are independent.
REQ-019 SHALL increment oFrameCnt by 1 per tick, wrapping 255 -> 0.
REQ-020 SHALL register hit_q each cycle = 1 iff both coords are valid, oPos_X <= iCoord_X < oPos_X + SPRITE_SIZE, and oPos_Y <= iCoord_Y < oPos_Y + SPRITE_SIZE.
REQ-021 SHALL register oRGB <= hit_q ? SPRITE_RGB : iRGB, giving a latency of 2 cycles from iCoord_* and 1 cycle from iRGB.
REQ-022 SHALL force hit_q = 0 when either coord equals 10'h3FF, so that iRGB passes through unchanged.
REQ-023 SHALL perform all comparisons at 11-bit width so that oPos + SPRITE_SIZE cannot wrap.
REQ-024 SHALL, when a tick coincides with an active-area hit, use the pre-tick position for that hit; ticks occur only in blanking.

Reset
REQ-025 SHALL, while iRst = 0, immediately hold oRGB = 0, oPos_X = 0, oPos_Y = 0, oFrameCnt = 0, direction = +X/+Y, hit_q = 0, vs_q = 1.
REQ-026 SHALL, on reset release mid-frame, emit no spurious tick; the first tick occurs on the next real iVs falling edge.

Configuration
REQ-027 SHALL, with VGA_SPRITE_BORDER_EN defined, output 24'hFFFFFF instead of SPRITE_RGB for hit pixels in the outer 2-pixel ring of the sprite (rel X or rel Y in {0, 1, SIZE-2, SIZE-1}).
REQ-028 SHALL, without VGA_SPRITE_BORDER_EN, fill the whole sprite with SPRITE_RGB and include no border logic.

Structure
REQ-029 SHALL place H_ACTIVE = 640, V_ACTIVE = 480, COORD_INVALID = 10'h3FF and the direction-flag typedef in shared package vga_pkg.
REQ-030 SHALL implement one sub-module, vga_bounce_axis, instantiated once per axis with parameter LIMIT; it holds position and direction and steps on tick.

Verification
REQ-031 SHALL cover reset: assert iRst = 0 -> oPos = (0,0), oFrameCnt = 0, oRGB = 0; release with iVs held high -> no change.
REQ-032 SHALL cover the first tick: one iVs falling edge -> oPos = (2,2), oFrameCnt = 1.
REQ-033 SHALL cover bounce: 300 ticks -> oPos_X = 600 with direction -X; tick 301 -> oPos_X = 598. 220 ticks -> oPos_Y = 440; tick 221 -> oPos_Y = 438.
REQ-034 SHALL cover compositing: pos (0,0), coord (39,39) then (40,0), with iRGB = 24'hFFFFFF -> oRGB = 24'h00FF00 two cycles later, then 24'hFFFFFF.
REQ-035 SHALL cover invalid passthrough: coord (3FF,10) inside the sprite Y span, iRGB = 24'hFF0000 -> oRGB = 24'hFF0000.
REQ-036 SHALL cover the border build: with VGA_SPRITE_BORDER_EN, pos (0,0), coord (1,20) -> 24'hFFFFFF; coord (2,20) -> 24'h00FF00.
